rv_multicycle_datapath: RTL and testbench

//  Parametrised multicycle RV32I-subset datapath. Successor to the single-shot datapath.

---
 rtl/rv_pkg.sv | 34 +++
 rtl/rv_alu.sv | 27 ++
 rtl/rv_multicycle_datapath.sv | 195 +++++++++++++++++++
 tb/tb_rv_multicycle_datapath.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared constants for the multicycle RV32I-subset datapath.
// Opcodes, funct fields, FSM state codes and ALU op codes.
package rv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_HALT   = 3'd5;

  typedef logic [1:0] alu_op_t;
  localparam alu_op_t ALU_ADD = 2'd0;
  localparam alu_op_t ALU_SUB = 2'd1;
  localparam alu_op_t ALU_AND = 2'd2;
  localparam alu_op_t ALU_OR  = 2'd3;

endpackage

// File: rtl/rv_alu.sv
// rv_alu: combinational add/sub/and/or plus equality flag.
// Ports: a_i, b_i operands; op_i selects y_o; eq_o = (a_i == b_i).
module rv_alu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_t         op_i,
  output logic [XLEN-1:0] y_o,
  output logic            eq_o
);

  always_comb begin
    y_o = a_i + b_i;
    unique case (op_i)
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      default: y_o = a_i + b_i;
    endcase
  end

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/rv_multicycle_datapath.sv
// rv_multicycle_datapath: multicycle RV32I subset (add sub and or addi lw sw beq).
// Ports: clk, reset (async active-low); instr_valid/instr/instr_ready fetch
// handshake at pc; busy, halted status; dbg_reg_*/dbg_mem_* async debug reads.
module rv_multicycle_datapath
  import rv_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              NREGS      = 32,
  parameter int              DMEM_WORDS = 64,
  parameter logic [XLEN-1:0] PC_RESET   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          instr_valid,
  input  logic [31:0]                   instr,
  output logic                          instr_ready,
  output logic [XLEN-1:0]               pc,
  output logic                          busy,
  output logic                          halted,
  input  logic [$clog2(NREGS)-1:0]      dbg_reg_addr,
  output logic [XLEN-1:0]               dbg_reg_data,
  input  logic [$clog2(DMEM_WORDS)-1:0] dbg_mem_addr,
  output logic [XLEN-1:0]               dbg_mem_data
);

  localparam int RW = $clog2(NREGS);
  localparam int MW = $clog2(DMEM_WORDS);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] mem_q [DMEM_WORDS];
  logic [XLEN-1:0] mem_d [DMEM_WORDS];

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [RW-1:0]   rs1, rs2, rd;
  logic            is_r, is_i, is_lw, is_sw, is_beq;
  logic            legal;
  alu_op_t         alu_op;
  logic [31:0]     imm32;
  logic [XLEN-1:0] alu_b, alu_y, pc_next;
  logic            alu_eq;
  logic [MW-1:0]   idx;

  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];
  assign f7  = ir_q[31:25];
  assign rs1 = ir_q[15 +: RW];
  assign rs2 = ir_q[20 +: RW];
  assign rd  = ir_q[7 +: RW];

  assign is_r   = (opc == OP);
  assign is_i   = (opc == OP_IMM);
  assign is_lw  = (opc == LOAD);
  assign is_sw  = (opc == STORE);
  assign is_beq = (opc == BRANCH);

  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    unique case (1'b1)
      is_r: begin
        legal = (f7 == F7_BASE &&
                 (f3 == F3_ADD || f3 == F3_AND || f3 == F3_OR)) ||
                (f7 == F7_SUB && f3 == F3_ADD);
        alu_op = (f7 == F7_SUB) ? ALU_SUB :
                 (f3 == F3_AND) ? ALU_AND :
                 (f3 == F3_OR)  ? ALU_OR  : ALU_ADD;
      end
      is_i:    legal = (f3 == F3_ADD);
      is_lw:   legal = (f3 == F3_W);
      is_sw:   legal = (f3 == F3_W);
      is_beq:  legal = (f3 == F3_BEQ);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
    if (is_sw)
      imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    else if (is_beq)
      imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
               ir_q[30:25], ir_q[11:8], 1'b0};
  end

  // beq compares A with B, so only immediate forms take imm
  assign alu_b   = (is_i || is_lw || is_sw) ? imm_q : b_q;
  assign pc_next = pc_q + XLEN'(3'd4);
  // low 2 address bits ignored; upper bits wrap over the depth
  assign idx     = alu_q[MW+1:2];

  rv_alu #(.XLEN(XLEN)) u_alu (
    .a_i  (a_q),
    .b_i  (alu_b),
    .op_i (alu_op),
    .y_o  (alu_y),
    .eq_o (alu_eq)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    regs_d  = regs_q;
    mem_d   = mem_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          a_d     = regs_q[rs1];
          b_d     = regs_q[rs2];
          imm_d   = XLEN'($signed(imm32));
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          pc_d    = alu_eq ? pc_q + imm_q : pc_next;
          state_d = S_IDLE;
        end else begin
          alu_d   = alu_y;
          state_d = (is_lw || is_sw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          mem_d[idx] = b_q;
          pc_d       = pc_next;
          state_d    = S_IDLE;
        end else begin
          alu_d   = mem_q[idx];
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (rd != '0)
          regs_d[rd] = alu_q;
        pc_d    = pc_next;
        state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      regs_q  <= '{default: '0};
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      regs_q  <= regs_d;
      mem_q   <= mem_d;
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign halted       = (state_q == S_HALT);
  assign busy         = !(state_q == S_IDLE || state_q == S_HALT);
  assign pc           = pc_q;
  assign dbg_reg_data = regs_q[dbg_reg_addr];
  assign dbg_mem_data = mem_q[dbg_mem_addr];

endmodule

// File: tb/tb_rv_multicycle_datapath.sv
// tb_rv_multicycle_datapath: random and directed checks of the multicycle
// datapath against an instruction-level model of the ISA subset.
module tb_rv_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready, busy, halted;
  logic [31:0] pc, dbg_reg_data, dbg_mem_data;
  logic [4:0]  dbg_reg_addr = '0;
  logic [5:0]  dbg_mem_addr = '0;

  int vectors = 0;
  int miscompares = 0;

  always #50 clk = ~clk;

  rv_multicycle_datapath #(
    .XLEN(32), .NREGS(32), .DMEM_WORDS(64), .PC_RESET(32'd0)
  ) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .pc(pc), .busy(busy), .halted(halted),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data)
  );

  // ISA-level reference state
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;

  function automatic logic [31:0] i_r(input logic [6:0] f7,
    input logic [2:0] f3, input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] i_add(input int rd, rs1, rs2);
    return i_r(7'h00, 3'b000, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] i_sub(input int rd, rs1, rs2);
    return i_r(7'h20, 3'b000, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] i_and(input int rd, rs1, rs2);
    return i_r(7'h00, 3'b111, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] i_or(input int rd, rs1, rs2);
    return i_r(7'h00, 3'b110, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] i_addi(input int rd, rs1, imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] i_lw(input int rd, rs1, imm);
    return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'h03};
  endfunction
  function automatic logic [31:0] i_sw(input int rs2, rs1, imm);
    logic [11:0] m;
    m = 12'(imm);
    return {m[11:5], 5'(rs2), 5'(rs1), 3'b010, m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] i_beq(input int rs1, rs2, imm);
    logic [12:0] m;
    m = 13'(imm);
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'b000,
            m[4:1], m[11], 7'h63};
  endfunction

  // Executes one instruction on the model; returns the number of
  // not-ready cycles the spec requires, or -1 for an illegal word.
  function automatic int model_exec(input logic [31:0] ins);
    logic [31:0] a, b, ii, is, ib, res;
    int rd, ix, cyc;
    a  = m_regs[ins[19:15]];
    b  = m_regs[ins[24:20]];
    rd = int'(ins[11:7]);
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    cyc = 3;
    case (ins[6:0])
      7'h33: begin
        case ({ins[31:25], ins[14:12]})
          10'b0000000_000: res = a + b;
          10'b0100000_000: res = a - b;
          10'b0000000_111: res = a & b;
          10'b0000000_110: res = a | b;
          default: return -1;
        endcase
      end
      7'h13: begin
        if (ins[14:12] != 3'b000) return -1;
        res = a + ii;
      end
      7'h03: begin
        if (ins[14:12] != 3'b010) return -1;
        ix = int'(((a + ii) >> 2) % 64);
        res = m_mem[ix];
        cyc = 4;
      end
      7'h23: begin
        if (ins[14:12] != 3'b010) return -1;
        ix = int'(((a + is) >> 2) % 64);
        m_mem[ix] = b;
        m_pc = m_pc + 4;
        return 3;
      end
      7'h63: begin
        if (ins[14:12] != 3'b000) return -1;
        m_pc = (a == b) ? m_pc + ib : m_pc + 4;
        return 2;
      end
      default: return -1;
    endcase
    if (rd != 0) m_regs[rd] = res;
    m_pc = m_pc + 4;
    return cyc;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 32; k++) m_regs[k] = '0;
    for (int k = 0; k < 64; k++) m_mem[k] = '0;
    m_pc = '0;
    @(negedge clk);
  endtask

  // Issues one instruction; cyc = not-ready cycles, -1 on timeout.
  task automatic run_instr(input logic [31:0] ins, output int cyc);
    int n;
    cyc = -1;
    for (int k = 0; k < 20 && !instr_ready; k++) @(negedge clk);
    if (!instr_ready) return;
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      if (instr_ready) break;
      n++;
      @(negedge clk);
    end
    if (instr_ready) cyc = n;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (pc !== 32'd0 || instr_ready !== 1'b1 || busy !== 1'b0 ||
        halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: pc=%h rdy=%b busy=%b halt=%b want 0 1 0 0",
               pc, instr_ready, busy, halted);
    end
    for (int k = 0; k < 32; k++) begin
      dbg_reg_addr = 5'(k);
      dbg_mem_addr = 6'(k);
      #1;
      vectors++;
      if (dbg_reg_data !== 32'd0 || dbg_mem_data !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_clr[%0d]: reg=%h mem=%h want 0",
                 k, dbg_reg_data, dbg_mem_data);
      end
    end
  endtask

  task automatic test_handshake();
    int cyc;
    run_instr(i_addi(2, 0, 77), cyc);
    void'(model_exec(i_addi(2, 0, 77)));
    dbg_reg_addr = 5'd2;
    repeat (10) begin
      @(negedge clk);
      #1;
      vectors++;
      if (pc !== m_pc || busy !== 1'b0 || instr_ready !== 1'b1 ||
          dbg_reg_data !== m_regs[2]) begin
        miscompares++;
        $display("FAIL idle_wait: pc=%h x2=%h busy=%b want pc=%h x2=%h",
                 pc, dbg_reg_data, busy, m_pc, m_regs[2]);
      end
    end
  endtask

  task automatic test_cycles();
    logic [31:0] ins;
    int cyc, req;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin ins = i_addi(2, 0, 11); req = 3; end
        1: begin ins = i_lw(3, 0, 4);    req = 4; end
        2: begin ins = i_sw(2, 0, 8);    req = 3; end
        default: begin ins = i_beq(0, 0, 12); req = 2; end
      endcase
      void'(model_exec(ins));
      run_instr(ins, cyc);
      vectors++;
      if (cyc !== req || pc !== m_pc) begin
        miscompares++;
        $display("FAIL cycles[%0d]: cyc=%0d pc=%h want cyc=%0d pc=%h",
                 k, cyc, pc, req, m_pc);
      end
    end
  endtask

  task automatic test_x0();
    int cyc;
    run_instr(i_addi(0, 0, 5), cyc);
    void'(model_exec(i_addi(0, 0, 5)));
    dbg_reg_addr = 5'd0;
    #1;
    vectors++;
    if (dbg_reg_data !== 32'd0) begin
      miscompares++;
      $display("FAIL x0_write: got %h want 0", dbg_reg_data);
    end
    run_instr(i_addi(2, 0, 1), cyc);
    void'(model_exec(i_addi(2, 0, 1)));
    run_instr(i_sub(3, 0, 2), cyc);
    void'(model_exec(i_sub(3, 0, 2)));
    dbg_reg_addr = 5'd3;
    #1;
    vectors++;
    if (dbg_reg_data !== 32'hFFFF_FFFF || m_regs[3] !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL sub_wrap: got %h want ffffffff", dbg_reg_data);
    end
  endtask

  task automatic test_mem_wrap();
    int cyc, v;
    v = int'($urandom_range(1, 2047));
    run_instr(i_addi(2, 0, v), cyc);
    void'(model_exec(i_addi(2, 0, v)));
    run_instr(i_sw(2, 0, 256), cyc);
    void'(model_exec(i_sw(2, 0, 256)));
    dbg_mem_addr = 6'd0;
    #1;
    vectors++;
    if (dbg_mem_data !== 32'(v)) begin
      miscompares++;
      $display("FAIL mem_wrap_sw: got %h want %h", dbg_mem_data, 32'(v));
    end
    run_instr(i_lw(4, 0, 512), cyc);
    void'(model_exec(i_lw(4, 0, 512)));
    dbg_reg_addr = 5'd4;
    #1;
    vectors++;
    if (dbg_reg_data !== 32'(v)) begin
      miscompares++;
      $display("FAIL mem_wrap_lw: got %h want %h", dbg_reg_data, 32'(v));
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int cyc, exp, rd, rs1, rs2, imm;
    for (int k = 1; k < 8; k++) begin
      ins = i_addi(k, 0, int'($urandom_range(0, 4095)) - 2048);
      void'(model_exec(ins));
      run_instr(ins, cyc);
    end
    for (int n = 0; n < 80; n++) begin
      rd  = int'($urandom_range(0, 7));
      rs1 = int'($urandom_range(0, 7));
      rs2 = int'($urandom_range(0, 7));
      imm = int'($urandom_range(0, 4095)) - 2048;
      case ($urandom_range(0, 7))
        0: ins = i_add(rd, rs1, rs2);
        1: ins = i_sub(rd, rs1, rs2);
        2: ins = i_and(rd, rs1, rs2);
        3: ins = i_or(rd, rs1, rs2);
        4: ins = i_addi(rd, rs1, imm);
        5: ins = i_lw(rd, rs1, imm);
        6: ins = i_sw(rs2, rs1, imm);
        default: ins = i_beq(rs1, rs2 % 2 == 0 ? rs1 : rs2,
                             (int'($urandom_range(0, 32)) - 16) * 4);
      endcase
      exp = model_exec(ins);
      run_instr(ins, cyc);
      vectors++;
      if (cyc !== exp || pc !== m_pc) begin
        miscompares++;
        $display("FAIL rnd_ctl[%0d] %h: cyc=%0d pc=%h want cyc=%0d pc=%h",
                 n, ins, cyc, pc, exp, m_pc);
      end
      for (int k = 0; k < 8; k++) begin
        dbg_reg_addr = 5'(k);
        #1;
        vectors++;
        if (dbg_reg_data !== m_regs[k]) begin
          miscompares++;
          $display("FAIL rnd_x%0d[%0d]: got %h want %h",
                   k, n, dbg_reg_data, m_regs[k]);
        end
      end
    end
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
        dbg_mem_addr = 6'(w * 32 + k);
        #1;
        vectors++;
        if (dbg_mem_data !== m_mem[w * 32 + k]) begin
          miscompares++;
          $display("FAIL rnd_mem[%0d]: got %h want %h",
                   w * 32 + k, dbg_mem_data, m_mem[w * 32 + k]);
        end
      end
    end
  endtask

  task automatic test_program();
    logic [31:0] prog [16];
    logic [31:0] acc [$];
    logic [31:0] exp_pcs [$];
    logic done, saw36;
    for (int k = 0; k < 16; k++) prog[k] = 32'h0000_007F;
    prog[0]  = i_addi(2, 0, 7);
    prog[1]  = i_sw(2, 0, 4);
    prog[2]  = i_lw(1, 0, 4);
    prog[3]  = i_add(2, 1, 0);
    prog[4]  = i_add(1, 1, 2);
    prog[5]  = i_add(1, 1, 2);
    prog[6]  = i_sub(1, 1, 2);
    prog[7]  = i_sub(1, 1, 2);
    prog[8]  = i_beq(1, 2, 8);
    prog[9]  = i_add(1, 1, 1);
    prog[10] = i_and(1, 1, 2);
    prog[11] = i_or(1, 1, 0);
    prog[12] = i_sw(1, 0, 0);
    do_reset();
    done = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (instr_ready && pc == 32'd52) begin
        done = 1'b1;
        break;
      end
      if (instr_ready) begin
        instr = prog[pc[5:2]];
        instr_valid = 1'b1;
        acc.push_back(pc);
      end else begin
        instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL prog_timeout: pc=%h want 00000034", pc);
    end
    for (int g = 0; g < 20 && m_pc != 32'd52; g++) begin
      exp_pcs.push_back(m_pc);
      void'(model_exec(prog[m_pc[5:2]]));
    end
    vectors++;
    if (acc.size() !== exp_pcs.size()) begin
      miscompares++;
      $display("FAIL prog_count: got %0d want %0d",
               acc.size(), exp_pcs.size());
    end
    saw36 = 1'b0;
    foreach (acc[k]) begin
      if (acc[k] == 32'd36) saw36 = 1'b1;
      if (k < exp_pcs.size()) begin
        vectors++;
        if (acc[k] !== exp_pcs[k]) begin
          miscompares++;
          $display("FAIL prog_pc[%0d]: got %h want %h",
                   k, acc[k], exp_pcs[k]);
        end
      end
    end
    vectors++;
    if (saw36 !== 1'b0) begin
      miscompares++;
      $display("FAIL prog_skip: pc 36 accepted, want skipped");
    end
    dbg_reg_addr = 5'd1;
    dbg_mem_addr = 6'd0;
    #1;
    vectors++;
    if (dbg_reg_data !== 32'd7 || dbg_mem_data !== 32'd7 ||
        m_regs[1] !== 32'd7) begin
      miscompares++;
      $display("FAIL prog_x1_m0: x1=%h m0=%h want 7 7",
               dbg_reg_data, dbg_mem_data);
    end
    dbg_reg_addr = 5'd2;
    dbg_mem_addr = 6'd1;
    #1;
    vectors++;
    if (dbg_reg_data !== 32'd7 || dbg_mem_data !== 32'd7) begin
      miscompares++;
      $display("FAIL prog_x2_m1: x2=%h m1=%h want 7 7",
               dbg_reg_data, dbg_mem_data);
    end
  endtask

  task automatic test_reset_mid_lw();
    int cyc;
    run_instr(i_addi(5, 0, 9), cyc);
    void'(model_exec(i_addi(5, 0, 9)));
    run_instr(i_sw(5, 0, 12), cyc);
    void'(model_exec(i_sw(5, 0, 12)));
    instr = i_lw(6, 0, 12);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midlw_busy: got %b want 1", busy);
    end
    reset = 1'b0;
    dbg_reg_addr = 5'd6;
    dbg_mem_addr = 6'd3;
    #1;
    vectors++;
    if (pc !== 32'd0 || instr_ready !== 1'b1 || halted !== 1'b0 ||
        dbg_reg_data !== 32'd0 || dbg_mem_data !== 32'd0) begin
      miscompares++;
      $display("FAIL midlw_abort: pc=%h rdy=%b x6=%h m3=%h want 0 1 0 0",
               pc, instr_ready, dbg_reg_data, dbg_mem_data);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 32; k++) m_regs[k] = '0;
    for (int k = 0; k < 64; k++) m_mem[k] = '0;
    m_pc = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (dbg_reg_data !== 32'd0 || busy !== 1'b0 || pc !== 32'd0) begin
      miscompares++;
      $display("FAIL midlw_after: x6=%h busy=%b pc=%h want 0 0 0",
               dbg_reg_data, busy, pc);
    end
  endtask

  task automatic test_illegal();
    int cyc;
    logic [31:0] p;
    run_instr(i_addi(7, 0, 123), cyc);
    void'(model_exec(i_addi(7, 0, 123)));
    p = m_pc;
    instr = 32'h0000_007F;
    instr_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL ill_early: halted=%b want 0", halted);
    end
    @(negedge clk);
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL ill_halt: halted=%b want 1", halted);
    end
    repeat (20) begin
      @(negedge clk);
      vectors++;
      if (instr_ready !== 1'b0 || halted !== 1'b1 || busy !== 1'b0 ||
          pc !== p) begin
        miscompares++;
        $display("FAIL ill_hold: rdy=%b halt=%b busy=%b pc=%h want 0 1 0 %h",
                 instr_ready, halted, busy, pc, p);
      end
    end
    for (int k = 0; k < 8; k++) begin
      dbg_reg_addr = 5'(k);
      #1;
      vectors++;
      if (dbg_reg_data !== m_regs[k]) begin
        miscompares++;
        $display("FAIL ill_x%0d: got %h want %h", k, dbg_reg_data, m_regs[k]);
      end
    end
    instr_valid = 1'b0;
    do_reset();
    vectors++;
    if (halted !== 1'b0 || instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ill_reset: halt=%b rdy=%b want 0 1", halted, instr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_cycles();
    test_x0();
    test_mem_wrap();
    test_random();
    test_program();
    test_reset_mid_lw();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
